// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the rv32i core: fetch handshake, decode, execute/memory/writeback sequencing.
// Optional macro MULTICYCLE_CTRL_TRAP_EN: illegal instructions park the FSM in TRAP until reset.
module multicycle_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [31:0] i_instr,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_valid,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic       o_illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t r_state;
  state_t w_nextState;
  logic   r_run;
  logic   w_active;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic       w_aluF3Ok;
  logic [2:0] w_aluOp;

  assign w_opcode   = i_instr[6:0];
  assign w_funct3   = i_instr[14:12];
  assign w_funct7b5 = i_instr[30];
  assign w_aluF3Ok  = (w_funct3 == 3'b000) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

  // r_run stays low for the first edge after reset so the first fetch request starts one cycle later.
  assign w_active = r_run & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run   <= 1'b0;
      r_state <= FETCH;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_aluOp = 3'b000;
    case (w_funct3)
      3'b000:  w_aluOp = (w_opcode == OP_RTYPE && w_funct7b5) ? 3'b001 : 3'b000;
      3'b110:  w_aluOp = 3'b110;
      3'b111:  w_aluOp = 3'b111;
      default: w_aluOp = 3'b000;
    endcase
  end

  always_comb begin
    w_nextState   = r_state;
    o_mem_valid   = 1'b0;
    o_mem_write   = 1'b0;
    o_adr_src     = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_result_src  = 2'b00;
    o_imm_src     = 2'b00;
    o_alu_control = 3'b000;
    o_illegal     = 1'b0;

    case (r_state)
      FETCH: begin
        o_mem_valid  = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
        if (i_mem_ready) w_nextState = DECODE;
      end
      DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        o_imm_src   = 2'b10;
        if ((w_opcode == OP_LOAD || w_opcode == OP_STORE) && w_funct3 == 3'b010)
          w_nextState = MEMADR;
        else if (w_opcode == OP_RTYPE && w_aluF3Ok)
          w_nextState = EXEC_R;
        else if (w_opcode == OP_ITYPE && w_aluF3Ok)
          w_nextState = EXEC_I;
        else if (w_opcode == OP_BRANCH && w_funct3 == 3'b000)
          w_nextState = BEQ;
        else if (w_opcode == OP_JAL)
          w_nextState = JAL;
        else begin
          o_illegal = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          w_nextState = TRAP;
`else
          w_nextState = FETCH;
`endif
        end
      end
      MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        // Opcode bit 5 separates store (S immediate) from load (I immediate).
        o_imm_src   = w_opcode[5] ? 2'b01 : 2'b00;
        w_nextState = w_opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_mem_valid = 1'b1;
        o_adr_src   = 1'b1;
        if (i_mem_ready) w_nextState = MEMWB;
      end
      MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        w_nextState  = FETCH;
      end
      MEMWRITE: begin
        o_mem_valid = 1'b1;
        o_mem_write = 1'b1;
        o_adr_src   = 1'b1;
        if (i_mem_ready) w_nextState = FETCH;
      end
      EXEC_R: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b00;
        o_alu_control = w_aluOp;
        w_nextState   = ALUWB;
      end
      EXEC_I: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b01;
        o_imm_src     = 2'b00;
        o_alu_control = w_aluOp;
        w_nextState   = ALUWB;
      end
      ALUWB: begin
        o_result_src = 2'b00;
        o_reg_write  = 1'b1;
        w_nextState  = FETCH;
      end
      BEQ: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b00;
        o_alu_control = 3'b001;
        o_pc_write    = i_zero;
        w_nextState   = FETCH;
      end
      JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
        o_imm_src   = 2'b11;
        w_nextState = ALUWB;
      end
      TRAP: begin
        o_illegal   = 1'b1;
        w_nextState = TRAP;
      end
      default: w_nextState = FETCH;
    endcase

    // Reset gates every output combinationally so a mid-instruction reset can never leave a partial write.
    if (!w_active) begin
      w_nextState   = r_state;
      o_mem_valid   = 1'b0;
      o_mem_write   = 1'b0;
      o_adr_src     = 1'b0;
      o_ir_write    = 1'b0;
      o_pc_write    = 1'b0;
      o_reg_write   = 1'b0;
      o_alu_src_a   = 2'b00;
      o_alu_src_b   = 2'b00;
      o_result_src  = 2'b00;
      o_imm_src     = 2'b00;
      o_alu_control = 3'b000;
      o_illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard testbench for multicycle_ctrl; expected output vectors are queued per cycle and compared at negedge.
// Honours MULTICYCLE_CTRL_TRAP_EN for the illegal-instruction sequence.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        memReady;
  logic        memValid, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
  logic [1:0]  aluSrcA, aluSrcB, resultSrc, immSrc;
  logic [2:0]  aluControl;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } sbEntry_t;

  sbEntry_t scoreboard[$];
  int assertCount = 0;
  int failCount   = 0;

  multicycle_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_zero(zero), .i_mem_ready(memReady),
    .o_mem_valid(memValid), .o_mem_write(memWrite), .o_adr_src(adrSrc),
    .o_ir_write(irWrite), .o_pc_write(pcWrite), .o_reg_write(regWrite),
    .o_alu_src_a(aluSrcA), .o_alu_src_b(aluSrcB), .o_result_src(resultSrc),
    .o_imm_src(immSrc), .o_alu_control(aluControl), .o_illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs one cycle's expected outputs in a fixed order matching observedVec().
  function automatic logic [17:0] mk(input logic mv, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ill);
    return {mv, mw, as, irw, pcw, rw, a, b, rs, imm, alu, ill};
  endfunction

  function automatic logic [17:0] observedVec();
    return {memValid, memWrite, adrSrc, irWrite, pcWrite, regWrite,
            aluSrcA, aluSrcB, resultSrc, immSrc, aluControl, illegal};
  endfunction

  // Per-state expected vectors taken directly from the state descriptions.
  function automatic logic [17:0] vFetch(input logic rdy);
    return mk(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vDecode(input logic ill);
    return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, ill);
  endfunction
  function automatic logic [17:0] vExecR(input logic [2:0] alu);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 0);
  endfunction
  function automatic logic [17:0] vExecI(input logic [2:0] alu);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 0);
  endfunction
  function automatic logic [17:0] vAluWb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vMemAdr(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vMemRead();
    return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vMemWb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vMemWrite();
    return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vBeq(input logic z);
    return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0);
  endfunction
  function automatic logic [17:0] vJal();
    return mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000, 0);
  endfunction
  function automatic logic [17:0] vZero();
    return 18'd0;
  endfunction
  function automatic logic [17:0] vTrap();
    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
  endfunction

  task automatic applyStimulus(input logic [31:0] newInstr, input logic newReady, input logic newZero);
    instr    = newInstr;
    memReady = newReady;
    zero     = newZero;
  endtask

  task automatic pushExpected(input string tag, input logic [17:0] exp);
    sbEntry_t e;
    e.tag = tag;
    e.exp = exp;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    sbEntry_t e;
    logic [17:0] obs;
    assertCount++;
    if (scoreboard.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", observedVec());
    end else begin
      e   = scoreboard.pop_front();
      obs = observedVec();
      assert (obs === e.exp) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle: queue the expectation, compare at negedge, then move to just after the next rising edge.
  task automatic cycle(input string tag, input logic [17:0] exp);
    pushExpected(tag, exp);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    cycle("idle_after_reset", vZero());
  endtask

  initial begin
    #20000;
    failCount++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0000_0000, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) cycle("reset_outputs", vZero());
    releaseReset();

    // add with one fetch wait state, then sub
    applyStimulus(32'h0020_81B3, 1'b0, 1'b0);
    cycle("add_fetch_wait", vFetch(1'b0));
    memReady = 1'b1;
    cycle("add_fetch", vFetch(1'b1));
    cycle("add_decode", vDecode(1'b0));
    cycle("add_exec", vExecR(3'b000));
    cycle("add_wb", vAluWb());

    applyStimulus(32'h4020_81B3, 1'b1, 1'b0);
    cycle("sub_fetch", vFetch(1'b1));
    cycle("sub_decode", vDecode(1'b0));
    cycle("sub_exec", vExecR(3'b001));
    cycle("sub_wb", vAluWb());

    applyStimulus(32'h0020_F1B3, 1'b1, 1'b0);
    cycle("and_fetch", vFetch(1'b1));
    cycle("and_decode", vDecode(1'b0));
    cycle("and_exec", vExecR(3'b111));
    cycle("and_wb", vAluWb());

    applyStimulus(32'h0020_E093, 1'b1, 1'b0);
    cycle("ori_fetch", vFetch(1'b1));
    cycle("ori_decode", vDecode(1'b0));
    cycle("ori_exec", vExecI(3'b110));
    cycle("ori_wb", vAluWb());

    // lw with two wait states in MEMREAD: 7 cycles in total
    applyStimulus(32'h0040_A283, 1'b1, 1'b0);
    cycle("lw_fetch", vFetch(1'b1));
    cycle("lw_decode", vDecode(1'b0));
    cycle("lw_memadr", vMemAdr(2'b00));
    memReady = 1'b0;
    cycle("lw_memread_wait1", vMemRead());
    cycle("lw_memread_wait2", vMemRead());
    memReady = 1'b1;
    cycle("lw_memread_done", vMemRead());
    cycle("lw_memwb", vMemWb());

    applyStimulus(32'h0020_A023, 1'b1, 1'b0);
    cycle("sw_fetch", vFetch(1'b1));
    cycle("sw_decode", vDecode(1'b0));
    cycle("sw_memadr", vMemAdr(2'b01));
    cycle("sw_memwrite", vMemWrite());

    applyStimulus(32'h0000_0463, 1'b1, 1'b1);
    cycle("beq_t_fetch", vFetch(1'b1));
    cycle("beq_t_decode", vDecode(1'b0));
    cycle("beq_taken", vBeq(1'b1));
    applyStimulus(32'h0000_0463, 1'b1, 1'b0);
    cycle("beq_n_fetch", vFetch(1'b1));
    cycle("beq_n_decode", vDecode(1'b0));
    cycle("beq_not_taken", vBeq(1'b0));

    applyStimulus(32'h0080_00EF, 1'b1, 1'b0);
    cycle("jal_fetch", vFetch(1'b1));
    cycle("jal_decode", vDecode(1'b0));
    cycle("jal_exec", vJal());
    cycle("jal_wb", vAluWb());

    // asynchronous reset in the middle of ALUWB
    applyStimulus(32'h0020_81B3, 1'b1, 1'b0);
    cycle("rst_add_fetch", vFetch(1'b1));
    cycle("rst_add_decode", vDecode(1'b0));
    cycle("rst_add_exec", vExecR(3'b000));
    pushExpected("rst_add_wb_before", vAluWb());
    @(negedge clk);
    checkOutput();
    #1;
    rst = 1'b1;
    #1;
    pushExpected("rst_mid_aluwb", vZero());
    checkOutput();
    @(posedge clk);
    #1;
    cycle("rst_held", vZero());
    releaseReset();

    // illegal instruction
    applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle("ill_fetch", vFetch(1'b1));
    cycle("ill_decode", vDecode(1'b1));
`ifdef MULTICYCLE_CTRL_TRAP_EN
    cycle("ill_trap1", vTrap());
    cycle("ill_trap2", vTrap());
    cycle("ill_trap3", vTrap());
    rst = 1'b1;
    #1;
    pushExpected("ill_trap_reset", vZero());
    checkOutput();
    @(posedge clk);
    #1;
    releaseReset();
    applyStimulus(32'h0020_81B3, 1'b1, 1'b0);
    cycle("post_trap_fetch", vFetch(1'b1));
`else
    applyStimulus(32'h0020_81B3, 1'b1, 1'b0);
    cycle("ill_back_to_fetch", vFetch(1'b1));
    cycle("post_ill_decode", vDecode(1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
